// File: rtl/divider_arbiter.sv
// divider_arbiter
// Shares one iterative divider between two requesters, A and B, with
// round-robin arbitration. It latches the winner's operands, runs the
// divider's Start/Ack handshake, and returns the result on the winner's
// own Done/Ack handshake. A zero divisor is answered locally, because the
// divider would never finish with Y=0.
//
// Ports
//   i_Clk, i_Reset              clock (rising edge), synchronous active-low reset
//   i_ReqA/B, i_XA/YA, i_XB/YB  requests and their dividend/divisor
//   i_AckA/B                    requester acknowledges its result
//   o_DoneA/B, o_QuoA/B, o_RemA/B  per-requester result and valid flag
//   o_DivZero                   last transaction had a zero divisor
//   o_Owner                     0=A, 1=B; current or most recent grant
//   o_Busy                      arbiter is not idle
//   o_LastCycles                cycles the last transaction spent waiting on the divider
//   o_Div_Xin/Yin, o_Div_Start, o_Div_Ack  divider operands and handshake
//   i_Div_Done, i_Div_Quotient, i_Div_Remainder  divider status and results
module divider_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 6
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_ReqA,
   input  logic             i_ReqB,
   input  logic [WIDTH-1:0] i_XA,
   input  logic [WIDTH-1:0] i_YA,
   input  logic [WIDTH-1:0] i_XB,
   input  logic [WIDTH-1:0] i_YB,
   input  logic             i_AckA,
   input  logic             i_AckB,
   output logic             o_DoneA,
   output logic             o_DoneB,
   output logic [WIDTH-1:0] o_QuoA,
   output logic [WIDTH-1:0] o_QuoB,
   output logic [WIDTH-1:0] o_RemA,
   output logic [WIDTH-1:0] o_RemB,
   output logic             o_DivZero,
   output logic             o_Owner,
   output logic             o_Busy,
   output logic [CNT_W-1:0] o_LastCycles,
   output logic [WIDTH-1:0] o_Div_Xin,
   output logic [WIDTH-1:0] o_Div_Yin,
   output logic             o_Div_Start,
   output logic             o_Div_Ack,
   input  logic             i_Div_Done,
   input  logic [WIDTH-1:0] i_Div_Quotient,
   input  logic [WIDTH-1:0] i_Div_Remainder
);

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      START = 5'b00010,
      WAIT  = 5'b00100,
      ACK   = 5'b01000,
      HOLD  = 5'b10000
   } StateT;

   StateT            r_state;
   StateT            w_nextState;
   logic             r_lastServed;
   logic             r_owner;
   logic             r_divZero;
   logic [WIDTH-1:0] r_xin;
   logic [WIDTH-1:0] r_yin;
   logic [WIDTH-1:0] r_quoA;
   logic [WIDTH-1:0] r_remA;
   logic [WIDTH-1:0] r_quoB;
   logic [WIDTH-1:0] r_remB;
   logic [CNT_W-1:0] r_lastCycles;

   logic             w_anyReq;
   logic             w_pickB;
   logic             w_grant;
   logic [WIDTH-1:0] w_winX;
   logic [WIDTH-1:0] w_winY;
   logic             w_ownerAck;

   // Arbitration: a lone requester wins; on a tie B wins only if A was served
   // last. A done divider left over in IDLE is acknowledged first, so no
   // grant is issued in that cycle.
   assign w_anyReq   = i_ReqA | i_ReqB;
   assign w_pickB    = i_ReqB & (~i_ReqA | ~r_lastServed);
   assign w_grant    = w_anyReq & ~i_Div_Done;
   assign w_winX     = w_pickB ? i_XB : i_XA;
   assign w_winY     = w_pickB ? i_YB : i_YA;
   assign w_ownerAck = r_owner ? i_AckB : i_AckA;

   // State register.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A zero divisor skips the divider and goes straight to
   // HOLD with a locally generated result.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_nextState = (w_winY == '0) ? HOLD : START;
            end
         end
         START:   w_nextState = WAIT;
         WAIT:    if (i_Div_Done) w_nextState = ACK;
         ACK:     w_nextState = HOLD;
         HOLD:    if (w_ownerAck) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Output decode. Div_Ack is also raised in IDLE while the divider still
   // reports Done, which walks a stranded divider back to its initial state.
   always_comb begin
      o_Div_Start = 1'b0;
      o_Div_Ack   = 1'b0;
      o_DoneA     = 1'b0;
      o_DoneB     = 1'b0;
      o_Busy      = (r_state != IDLE);
      case (r_state)
         IDLE:  o_Div_Ack   = i_Div_Done;
         START: o_Div_Start = 1'b1;
         ACK:   o_Div_Ack   = 1'b1;
         HOLD: begin
            o_DoneA = ~r_owner;
            o_DoneB = r_owner;
         end
         default: ;
      endcase
   end

   // Datapath: operand latch at grant, wait-cycle counter, result capture into
   // the owner's registers only, and the round-robin pointer update on the
   // owner's acknowledge. The pointer resets to "B served last" so A wins the
   // first tie.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         r_lastServed <= 1'b1;
         r_owner      <= 1'b0;
         r_divZero    <= 1'b0;
         r_xin        <= '0;
         r_yin        <= '0;
         r_quoA       <= '0;
         r_remA       <= '0;
         r_quoB       <= '0;
         r_remB       <= '0;
         r_lastCycles <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_owner      <= w_pickB;
                  r_xin        <= w_winX;
                  r_yin        <= w_winY;
                  r_lastCycles <= '0;
                  if (w_winY == '0) begin
                     r_divZero <= 1'b1;
                     if (w_pickB) begin
                        r_quoB <= '1;
                        r_remB <= w_winX;
                     end else begin
                        r_quoA <= '1;
                        r_remA <= w_winX;
                     end
                  end
               end
            end
            WAIT: begin
               if (r_lastCycles != '1) begin
                  r_lastCycles <= r_lastCycles + CNT_W'(1);
               end
               if (i_Div_Done) begin
                  r_divZero <= 1'b0;
                  if (r_owner) begin
                     r_quoB <= i_Div_Quotient;
                     r_remB <= i_Div_Remainder;
                  end else begin
                     r_quoA <= i_Div_Quotient;
                     r_remA <= i_Div_Remainder;
                  end
               end
            end
            HOLD: begin
               if (w_ownerAck) begin
                  r_lastServed <= r_owner;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_QuoA       = r_quoA;
   assign o_RemA       = r_remA;
   assign o_QuoB       = r_quoB;
   assign o_RemB       = r_remB;
   assign o_DivZero    = r_divZero;
   assign o_Owner      = r_owner;
   assign o_LastCycles = r_lastCycles;
   assign o_Div_Xin    = r_xin;
   assign o_Div_Yin    = r_yin;

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter. A small behavioural divider answers the
// Start/Ack handshake with a fixed compute latency; expected results are
// hand-computed constants.
module tb_divider_arbiter;

   localparam int WIDTH = 4;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             reqA = 1'b0, reqB = 1'b0, ackA = 1'b0, ackB = 1'b0;
   logic [WIDTH-1:0] xa = '0, ya = '0, xb = '0, yb = '0;
   logic             doneA, doneB, divZero, owner, busy, divStart, divAck;
   logic [WIDTH-1:0] quoA, quoB, remA, remB, divXin, divYin;
   logic [CNT_W-1:0] lastCycles;
   logic             divDoneIn;

   // Behavioural divider state: 0 = initial, 1 = compute, 2 = done.
   logic [1:0]       divState = 2'd0;
   logic [2:0]       divCnt = 3'd0;
   logic             divDone = 1'b0;
   logic             forceDone = 1'b0;
   logic [WIDTH-1:0] divQ = '0, divR = '0;

   int numCompared = 0;
   int numMismatched = 0;
   int startCount = 0;
   int ackCount = 0;
   int doneBViolations = 0;
   int overlapCount = 0;

   assign divDoneIn = divDone | forceDone;

   always #5 clk = ~clk;

   divider_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_ReqA(reqA), .i_ReqB(reqB),
      .i_XA(xa), .i_YA(ya), .i_XB(xb), .i_YB(yb),
      .i_AckA(ackA), .i_AckB(ackB),
      .o_DoneA(doneA), .o_DoneB(doneB),
      .o_QuoA(quoA), .o_QuoB(quoB), .o_RemA(remA), .o_RemB(remB),
      .o_DivZero(divZero), .o_Owner(owner), .o_Busy(busy),
      .o_LastCycles(lastCycles),
      .o_Div_Xin(divXin), .o_Div_Yin(divYin),
      .o_Div_Start(divStart), .o_Div_Ack(divAck),
      .i_Div_Done(divDoneIn),
      .i_Div_Quotient(divQ), .i_Div_Remainder(divR)
   );

   // Divider model: three cycles of compute after Start, then Done until Ack.
   always @(posedge clk) begin
      if (!rst) begin
         divState <= 2'd0;
         divDone  <= 1'b0;
      end else begin
         case (divState)
            2'd0: if (divStart) begin
               divQ     <= (divYin != 0) ? divXin / divYin : '1;
               divR     <= (divYin != 0) ? divXin % divYin : divXin;
               divCnt   <= 3'd3;
               divState <= 2'd1;
            end
            2'd1: if (divCnt == 3'd1) begin
               divState <= 2'd2;
               divDone  <= 1'b1;
            end else begin
               divCnt <= divCnt - 3'd1;
            end
            default: if (divAck) begin
               divState <= 2'd0;
               divDone  <= 1'b0;
            end
         endcase
      end
   end

   // Handshake monitors, sampled away from the active edge.
   always @(negedge clk) begin
      if (divStart === 1'b1) startCount++;
      if (divAck === 1'b1) ackCount++;
      if (doneB === 1'b1 && owner === 1'b0) doneBViolations++;
      if (divStart === 1'b1 && divAck === 1'b1) overlapCount++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rA, input logic [WIDTH-1:0] xA, input logic [WIDTH-1:0] yA,
                                input logic rB, input logic [WIDTH-1:0] xB, input logic [WIDTH-1:0] yB);
      reqA = rA; xa = xA; ya = yA;
      reqB = rB; xb = xB; yb = yB;
   endtask

   // mode 0 waits for DoneA, 1 for DoneB, 2 for either.
   task automatic waitDone(input int mode, input int budget, output int cycles);
      logic seen;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < budget) begin
         seen = (mode == 0) ? (doneA === 1'b1) : (mode == 1) ? (doneB === 1'b1) : (doneA === 1'b1 || doneB === 1'b1);
         if (!seen) begin
            @(negedge clk);
            cycles++;
         end
      end
      if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
   endtask

   // Acknowledge one cycle after Done was observed, for one cycle.
   task automatic ackOwner(input logic forB);
      @(negedge clk);
      if (forB) ackB = 1'b1; else ackA = 1'b1;
      @(negedge clk);
      ackA = 1'b0;
      ackB = 1'b0;
   endtask

   int cycles;
   logic expOwner [3];
   logic curOwner;

   initial begin
      // Reset held with a pending request.
      applyStimulus(1'b1, 4'd13, 4'd4, 1'b0, 4'd0, 4'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstDone", {30'd0, doneA, doneB}, 32'd0);
      checkOutput("rstQuoRem", {16'd0, quoA, remA, quoB, remB}, 32'd0);
      checkOutput("rstFlags", {29'd0, divZero, owner, busy}, 32'd0);
      checkOutput("rstLastCycles", {26'd0, lastCycles}, 32'd0);
      checkOutput("rstDivIo", {22'd0, divXin, divYin, divStart, divAck}, 32'd0);
      checkOutput("rstNoStart", startCount, 32'd0);

      // Single A transaction, 13 / 4.
      startCount = 0;
      ackCount = 0;
      rst = 1'b1;
      waitDone(0, 30, cycles);
      checkOutput("aQuo", {28'd0, quoA}, 32'd3);
      checkOutput("aRem", {28'd0, remA}, 32'd1);
      checkOutput("aDivZero", {31'd0, divZero}, 32'd0);
      checkOutput("aOwner", {31'd0, owner}, 32'd0);
      checkOutput("aStartPulses", startCount, 32'd1);
      checkOutput("aAckPulses", ackCount, 32'd1);
      checkOutput("aLastCycles", {26'd0, lastCycles}, 32'd4);
      checkOutput("aLatency", cycles >= 4, 32'd1);
      checkOutput("aDoneBLow", {31'd0, doneB}, 32'd0);
      reqA = 1'b0;
      ackOwner(1'b0);
      checkOutput("aDoneFall", {30'd0, doneA, busy}, 32'd0);
      checkOutput("aQuoHeld", {28'd0, quoA}, 32'd3);

      // Fresh pointer, both requesters held: grants alternate A, B, A.
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 4'd15, 4'd1, 1'b1, 4'd9, 4'd3);
      expOwner[0] = 1'b0;
      expOwner[1] = 1'b1;
      expOwner[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         waitDone(2, 30, cycles);
         curOwner = owner;
         checkOutput($sformatf("rrOwner%0d", i), {31'd0, owner}, {31'd0, expOwner[i]});
         if (expOwner[i]) begin
            checkOutput($sformatf("rrQuoRemB%0d", i), {24'd0, quoB, remB}, {24'd0, 4'd3, 4'd0});
         end else begin
            checkOutput($sformatf("rrQuoRemA%0d", i), {24'd0, quoA, remA}, {24'd0, 4'd15, 4'd0});
         end
         if (i == 2) applyStimulus(1'b0, 4'd15, 4'd1, 1'b0, 4'd9, 4'd3);
         ackOwner(curOwner);
      end
      checkOutput("rrDoneBOnlyWhenOwnerB", doneBViolations, 32'd0);

      // B divides by zero: handled locally without starting the divider.
      startCount = 0;
      applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 4'd0);
      waitDone(1, 2, cycles);
      checkOutput("zQuoRemB", {24'd0, quoB, remB}, {24'd0, 4'hF, 4'd7});
      checkOutput("zDivZero", {31'd0, divZero}, 32'd1);
      checkOutput("zOwner", {31'd0, owner}, 32'd1);
      checkOutput("zNoStart", startCount, 32'd0);
      checkOutput("zLastCycles", {26'd0, lastCycles}, 32'd0);
      checkOutput("zQuoAHeld", {24'd0, quoA, remA}, {24'd0, 4'd15, 4'd0});
      reqB = 1'b0;
      ackOwner(1'b1);
      checkOutput("zDoneFall", {31'd0, doneB}, 32'd0);

      // Reset while the divider is computing, then a clean transaction.
      applyStimulus(1'b1, 4'd15, 4'd1, 1'b0, 4'd0, 4'd0);
      cycles = 0;
      while (divStart !== 1'b1 && cycles < 10) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("wStartSeen", {31'd0, divStart}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      reqA = 1'b0;
      @(negedge clk);
      checkOutput("wRstIdle", {30'd0, busy, doneA}, 32'd0);
      checkOutput("wRstCleared", {27'd0, quoA, owner}, 32'd0);
      rst = 1'b1;
      applyStimulus(1'b1, 4'd6, 4'd2, 1'b0, 4'd0, 4'd0);
      waitDone(0, 30, cycles);
      checkOutput("wQuoRemA", {24'd0, quoA, remA}, {24'd0, 4'd3, 4'd0});
      reqA = 1'b0;
      ackOwner(1'b0);

      // Stale divider Done while idle: acknowledge, no grant, then normal grant.
      forceDone = 1'b1;
      applyStimulus(1'b1, 4'd9, 4'd2, 1'b0, 4'd0, 4'd0);
      #1;
      checkOutput("sAckWhileIdle", {30'd0, divAck, busy}, 32'd2);
      @(negedge clk);
      checkOutput("sNoGrant", {31'd0, busy}, 32'd0);
      forceDone = 1'b0;
      waitDone(0, 30, cycles);
      checkOutput("sQuoRemA", {24'd0, quoA, remA}, {24'd0, 4'd4, 4'd1});
      reqA = 1'b0;
      ackOwner(1'b0);

      checkOutput("startAckOverlap", overlapCount, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
